// File: rtl/img_pkg.sv
// img_pkg: shared types and constants for the image pattern generator.
//   ImgGenState   - generator FSM states
//   ImgMode*      - pixel pattern select encodings
//   clog2_min1    - counter width helper (never returns 0)
package img_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FV_LEAD,
    LINE,
    LINE_GAP,
    FRAME_GAP
  } ImgGenState;

  localparam logic [1:0] ImgModeInvCount = 2'd0;
  localparam logic [1:0] ImgModeCount    = 2'd1;
  localparam logic [1:0] ImgModeChecker  = 2'd2;
  localparam logic [1:0] ImgModeConst    = 2'd3;

  // Bits needed to count 0..n-1, at least 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_px_pattern.sv
// img_px_pattern: combinational pixel value for the current pattern.
//   i_mode  - latched pattern select
//   i_px    - frame pixel counter
//   i_row   - low two bits of the row of the pixel being produced
//   i_col   - low two bits of the column of the pixel being produced
//   i_const - latched constant pixel value
//   o_pix   - pixel value
module img_px_pattern
  import img_pkg::*;
#(
  parameter int PixelWidth = 12
) (
  input  logic [1:0]            i_mode,
  input  logic [PixelWidth-1:0] i_px,
  input  logic [1:0]            i_row,
  input  logic [1:0]            i_col,
  input  logic [PixelWidth-1:0] i_const,
  output logic [PixelWidth-1:0] o_pix
);

  always_comb begin
    o_pix = '0;
    case (i_mode)
      ImgModeInvCount: o_pix = ~i_px;
      ImgModeCount:    o_pix = i_px;
      // Sparse grid: one bright pixel per 4x4 tile.
      ImgModeChecker:  o_pix = (i_row == 2'd0 && i_col == 2'd0) ? '1 : '0;
      ImgModeConst:    o_pix = i_const;
      default:         o_pix = '0;
    endcase
  end

endmodule

// File: rtl/img_pattern_gen.sv
// img_pattern_gen: synthetic image sensor producing a frame/line-valid
// pixel stream with configurable geometry, blanking and test patterns.
//   clk         - clock, all outputs registered on rising edge
//   rst_        - asynchronous active-low reset
//   en          - run request, sampled in IDLE and on last frame-gap cycle
//   mode        - pattern select, latched at frame start
//   const_val   - constant pixel for mode 3, latched at frame start
//   img_d       - pixel data (0 while img_lv is low)
//   img_fv      - frame valid
//   img_lv      - line valid
//   busy        - generator not idle
//   frame_done  - one-cycle pulse with the falling edge of img_fv
//   frame_count - completed frames, wraps at 16 bits
module img_pattern_gen
  import img_pkg::*;
#(
  parameter int ImgWidth       = 256,
  parameter int ImgHeight      = 256,
  parameter int PixelWidth     = 12,
  parameter int FvLeadCycles   = 6,
  parameter int LineGapCycles  = 6,
  parameter int FrameGapCycles = 6
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [PixelWidth-1:0] const_val,
  output logic [PixelWidth-1:0] img_d,
  output logic                  img_fv,
  output logic                  img_lv,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int ColW   = clog2_min1(ImgWidth);
  localparam int RowW   = clog2_min1(ImgHeight);
  localparam int MaxA   = (FvLeadCycles > ImgWidth) ? FvLeadCycles : ImgWidth;
  localparam int MaxB   = (LineGapCycles > FrameGapCycles) ? LineGapCycles : FrameGapCycles;
  localparam int CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  // One down-counter shared by every timed phase; holds phase length - 1.
  localparam int CntW   = clog2_min1(CntMax);

  ImgGenState            r_state, w_state_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [PixelWidth-1:0] r_px, w_px_nxt;
  logic [RowW-1:0]       r_row, w_row_nxt;
  logic [ColW-1:0]       r_col, w_col_nxt;
  logic [1:0]            r_mode, w_mode_nxt;
  logic [PixelWidth-1:0] r_const, w_const_nxt;
  logic [PixelWidth-1:0] r_d, w_d_nxt;
  logic                  r_fv, w_fv_nxt;
  logic                  r_lv, w_lv_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [15:0]           r_fcnt, w_fcnt_nxt;

  logic                  w_start;
  logic                  w_emit;
  logic [RowW-1:0]       w_pat_row;
  logic [PixelWidth-1:0] w_pix;

  // Leaving LINE_GAP into the next line emits that line's first pixel,
  // so the pattern must see the row it is about to become.
  assign w_pat_row = (r_state == LINE_GAP) ? r_row + RowW'(1) : r_row;

  img_px_pattern #(.PixelWidth(PixelWidth)) u_pat (
    .i_mode  (r_mode),
    .i_px    (r_px),
    .i_row   (2'(w_pat_row)),
    .i_col   (2'(r_col)),
    .i_const (r_const),
    .o_pix   (w_pix)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_px_nxt    = r_px;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_mode_nxt  = r_mode;
    w_const_nxt = r_const;
    w_fv_nxt    = r_fv;
    w_lv_nxt    = 1'b0;
    w_d_nxt     = '0;
    w_done_nxt  = 1'b0;
    w_fcnt_nxt  = r_fcnt;
    w_start     = 1'b0;
    w_emit      = 1'b0;

    case (r_state)
      IDLE: w_start = en;
      FV_LEAD: begin
        if (r_cnt == '0) begin
          w_emit      = 1'b1;
          w_state_nxt = LINE;
          w_cnt_nxt   = CntW'(ImgWidth - 1);
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      LINE: begin
        if (r_cnt == '0) begin
          w_state_nxt = LINE_GAP;
          w_cnt_nxt   = CntW'(LineGapCycles - 1);
          w_col_nxt   = '0;
        end else begin
          w_emit    = 1'b1;
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      LINE_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end else if (r_row < RowW'(ImgHeight - 1)) begin
          w_row_nxt   = r_row + RowW'(1);
          w_emit      = 1'b1;
          w_state_nxt = LINE;
          w_cnt_nxt   = CntW'(ImgWidth - 1);
        end else begin
          w_state_nxt = FRAME_GAP;
          w_cnt_nxt   = CntW'(FrameGapCycles - 1);
          w_fv_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_fcnt_nxt  = r_fcnt + 16'd1;
        end
      end
      FRAME_GAP: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CntW'(1);
        else if (en)     w_start = 1'b1;
        else             w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_emit) begin
      w_lv_nxt  = 1'b1;
      w_d_nxt   = w_pix;
      w_px_nxt  = r_px + PixelWidth'(1);
      w_col_nxt = r_col + ColW'(1);
    end

    // Frame start: settings are captured here and held for the whole frame.
    if (w_start) begin
      w_state_nxt = FV_LEAD;
      w_cnt_nxt   = CntW'(FvLeadCycles - 1);
      w_fv_nxt    = 1'b1;
      w_mode_nxt  = mode;
      w_const_nxt = const_val;
      w_px_nxt    = '0;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_px    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_mode  <= '0;
      r_const <= '0;
      r_d     <= '0;
      r_fv    <= 1'b0;
      r_lv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_px    <= w_px_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_mode  <= w_mode_nxt;
      r_const <= w_const_nxt;
      r_d     <= w_d_nxt;
      r_fv    <= w_fv_nxt;
      r_lv    <= w_lv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  assign img_d       = r_d;
  assign img_fv      = r_fv;
  assign img_lv      = r_lv;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_img_pattern_gen.sv
// tb_img_pattern_gen: directed bench for img_pattern_gen.
//   u_a: 4x2, 12-bit   (modes 0/1/3, continuous run, stop, reset)
//   u_b: 8x5, 12-bit   (mode 2 grid)
//   u_c: 6x1, 2-bit    (pixel counter wrap)
module tb_img_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic        a_en, b_en, c_en;
  logic [1:0]  a_mode, b_mode, c_mode;
  logic [11:0] a_cv, b_cv;
  logic [1:0]  c_cv;
  logic [11:0] a_d, b_d;
  logic [1:0]  c_d;
  logic        a_fv, a_lv, a_busy, a_done;
  logic        b_fv, b_lv, b_busy, b_done;
  logic        c_fv, c_lv, c_busy, c_done;
  logic [15:0] a_fc, b_fc, c_fc;

  img_pattern_gen #(.ImgWidth(4), .ImgHeight(2), .PixelWidth(12),
    .FvLeadCycles(6), .LineGapCycles(6), .FrameGapCycles(6)) u_a (
    .clk(clk), .rst_(rst_), .en(a_en), .mode(a_mode), .const_val(a_cv),
    .img_d(a_d), .img_fv(a_fv), .img_lv(a_lv), .busy(a_busy),
    .frame_done(a_done), .frame_count(a_fc));

  img_pattern_gen #(.ImgWidth(8), .ImgHeight(5), .PixelWidth(12),
    .FvLeadCycles(6), .LineGapCycles(6), .FrameGapCycles(6)) u_b (
    .clk(clk), .rst_(rst_), .en(b_en), .mode(b_mode), .const_val(b_cv),
    .img_d(b_d), .img_fv(b_fv), .img_lv(b_lv), .busy(b_busy),
    .frame_done(b_done), .frame_count(b_fc));

  img_pattern_gen #(.ImgWidth(6), .ImgHeight(1), .PixelWidth(2),
    .FvLeadCycles(6), .LineGapCycles(6), .FrameGapCycles(6)) u_c (
    .clk(clk), .rst_(rst_), .en(c_en), .mode(c_mode), .const_val(c_cv),
    .img_d(c_d), .img_fv(c_fv), .img_lv(c_lv), .busy(c_busy),
    .frame_done(c_done), .frame_count(c_fc));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor, sampled 1 time unit after each rising edge.
  int          cyc = 0;
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [1:0]  qc[$];
  int          a_rise[$];
  int          a_fv_tot = 0, a_done_tot = 0, b_fv_tot = 0, a_dz_bad = 0;
  logic        a_fv_q = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (a_lv) qa.push_back(a_d);
    else if (a_d !== 12'h0) a_dz_bad++;
    if (a_fv && !a_fv_q) a_rise.push_back(cyc);
    a_fv_q = a_fv;
    if (a_fv) a_fv_tot++;
    if (a_done) a_done_tot++;
    if (b_lv) qb.push_back(b_d);
    if (b_fv) b_fv_tot++;
    if (c_lv) qc.push_back(c_d);
  end

  task automatic wait_idle_a(input string tag);
    for (int k = 0; k < 400 && a_busy; k++) @(negedge clk);
    chk(tag, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_done_a(input int target, input string tag);
    for (int k = 0; k < 500 && a_done_tot < target; k++) @(negedge clk);
    chk(tag, 32'(a_done_tot >= target), 32'd1);
  endtask

  task automatic wait_lv_a(input string tag);
    for (int k = 0; k < 100 && !a_lv; k++) @(negedge clk);
    chk(tag, 32'(a_lv), 32'd1);
  endtask

  initial begin
    int s, r, f, d;
    rst_ = 1'b0;
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
    a_mode = 2'd0; b_mode = 2'd0; c_mode = 2'd0;
    a_cv = 12'h0; b_cv = 12'h0; c_cv = 2'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_fv",   32'(a_fv),   32'd0);
    chk("rst_lv",   32'(a_lv),   32'd0);
    chk("rst_d",    32'(a_d),    32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_fc",   32'(a_fc),   32'd0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("idle_no_en", 32'(a_busy), 32'd0);

    // Mode 0, single-cycle en pulse
    s = qa.size(); f = a_fv_tot; d = a_done_tot;
    a_mode = 2'd0; a_en = 1'b1;
    @(negedge clk);
    chk("t1_fv_latency", 32'(a_fv), 32'd1);
    a_en = 1'b0;
    wait_idle_a("t1_idle");
    chk("t1_fv_cycles", 32'(a_fv_tot - f), 32'd26);
    chk("t1_npix", 32'(qa.size() - s), 32'd8);
    for (int i = 0; i < 8; i++) chk("t1_pix", 32'(qa[s+i]), 32'(12'hFFF - i));
    chk("t1_done_pulses", 32'(a_done_tot - d), 32'd1);
    chk("t1_fc", 32'(a_fc), 32'd1);

    // Continuous mode 1 from a fresh reset
    rst_ = 1'b0;
    @(negedge clk);
    chk("t2_rst_fc", 32'(a_fc), 32'd0);
    rst_ = 1'b1;
    s = qa.size(); r = a_rise.size(); d = a_done_tot;
    a_mode = 2'd1; a_en = 1'b1;
    wait_done_a(d + 3, "t2_timeout");
    a_en = 1'b0;
    wait_idle_a("t2_idle");
    chk("t2_fc", 32'(a_fc), 32'd3);
    chk("t2_nrise", 32'(a_rise.size() - r), 32'd3);
    chk("t2_period1", 32'(a_rise[r+1] - a_rise[r]), 32'd32);
    chk("t2_period2", 32'(a_rise[r+2] - a_rise[r+1]), 32'd32);
    chk("t2_npix", 32'(qa.size() - s), 32'd24);
    for (int i = 0; i < 24; i++) chk("t2_pix", 32'(qa[s+i]), 32'(i % 8));

    // Mode 3: const and mode changed mid-frame
    s = qa.size(); d = a_done_tot;
    a_mode = 2'd3; a_cv = 12'h5A5; a_en = 1'b1;
    wait_lv_a("t3_start");
    @(negedge clk); @(negedge clk);
    a_cv = 12'h123; a_mode = 2'd1;
    repeat (4) @(negedge clk);
    a_mode = 2'd3;
    wait_done_a(d + 2, "t3_timeout");
    a_en = 1'b0;
    wait_idle_a("t3_idle");
    chk("t3_npix", 32'(qa.size() - s), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("t3_pix", 32'(qa[s+i]), (i < 8) ? 32'h5A5 : 32'h123);

    // Drop en mid-frame: frame still completes
    s = qa.size(); f = a_fv_tot; d = a_done_tot;
    a_mode = 2'd1; a_en = 1'b1;
    wait_lv_a("t4_start");
    a_en = 1'b0;
    wait_idle_a("t4_idle");
    chk("t4_npix", 32'(qa.size() - s), 32'd8);
    chk("t4_fv_cycles", 32'(a_fv_tot - f), 32'd26);
    chk("t4_done", 32'(a_done_tot - d), 32'd1);
    chk("t4_last_pix", 32'(qa[s+7]), 32'd7);

    // Reset during line 1, pixel 2 (px 6)
    a_mode = 2'd1; a_en = 1'b1;
    for (int k = 0; k < 100 && !(a_lv && a_d == 12'd6); k++) @(negedge clk);
    chk("t5_reach_px6", 32'(a_lv && a_d == 12'd6), 32'd1);
    #1 rst_ = 1'b0;
    #1;
    chk("t5_async_fv",   32'(a_fv),   32'd0);
    chk("t5_async_lv",   32'(a_lv),   32'd0);
    chk("t5_async_d",    32'(a_d),    32'd0);
    chk("t5_async_busy", 32'(a_busy), 32'd0);
    chk("t5_async_fc",   32'(a_fc),   32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    s = qa.size();
    @(negedge clk);
    chk("t5_restart_fv", 32'(a_fv), 32'd1);
    a_en = 1'b0;
    wait_idle_a("t5_idle");
    chk("t5_npix", 32'(qa.size() - s), 32'd8);
    chk("t5_first_pix", 32'(qa[s]), 32'd0);
    chk("t5_last_pix", 32'(qa[s+7]), 32'd7);
    chk("t5_fc", 32'(a_fc), 32'd1);

    // Mode 2 grid on 8x5
    s = qb.size(); f = b_fv_tot;
    b_mode = 2'd2; b_en = 1'b1;
    @(negedge clk);
    b_en = 1'b0;
    for (int k = 0; k < 400 && b_busy; k++) @(negedge clk);
    chk("t6_idle", 32'(b_busy), 32'd0);
    chk("t6_fv_cycles", 32'(b_fv_tot - f), 32'd76);
    chk("t6_npix", 32'(qb.size() - s), 32'd40);
    for (int i = 0; i < 40; i++)
      chk("t6_pix", 32'(qb[s+i]),
          (((i / 8) % 4 == 0) && ((i % 8) % 4 == 0)) ? 32'hFFF : 32'h0);
    chk("t6_fc", 32'(b_fc), 32'd1);

    // 2-bit pixel counter wrap
    s = qc.size();
    c_mode = 2'd1; c_en = 1'b1;
    @(negedge clk);
    c_en = 1'b0;
    for (int k = 0; k < 200 && c_busy; k++) @(negedge clk);
    chk("t7_idle", 32'(c_busy), 32'd0);
    chk("t7_npix", 32'(qc.size() - s), 32'd6);
    for (int i = 0; i < 6; i++) chk("t7_pix", 32'(qc[s+i]), 32'(i % 4));
    chk("t7_done_seen", 32'(c_fc), 32'd1);

    chk("d_zero_when_lv_low", 32'(a_dz_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/img_pattern_gen.md
# img_pattern_gen

Synthesizable, parametrised image-sensor stand-in that drives a frame/line-valid pixel stream (`img_d`, `img_fv`, `img_lv`) with the same framing as the sensor interface. The pipeline can then be exercised on hardware, and in simulation, without a sensor attached. It sits in front of the image capture path in place of the sensor pins. Compared with the behavioural sensor model, it adds:
- configurable pixel width and blanking;
- run/stop control at frame boundaries;
- four selectable pixel patterns;
- frame status outputs.

## Interface
Parameters:
- `ImgWidth`, 256, pixels per line (≥1)
- `ImgHeight`, 256, lines per frame (≥1)
- `PixelWidth`, 12, bits per pixel (1–16)
- `FvLeadCycles`, 6, cycles between `img_fv` rise and first `img_lv` rise (≥1)
- `LineGapCycles`, 6, `img_lv`-low cycles after every line, including the last (≥1)
- `FrameGapCycles`, 6, `img_fv`-low cycles between frames (≥1)

Ports:
- `clk` in 1: single clock; every output is registered on its rising edge.
- `rst_` in 1: reset, asynchronous and active-low.
- `en` in 1: run request; frames repeat while high.
- `mode` in 2: pattern select.
- `const_val` in PixelWidth: pixel value used in mode 3.
- `img_d` out PixelWidth: pixel data.
- `img_fv` out 1: frame valid.
- `img_lv` out 1: line valid.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse coincident with `img_fv` falling.
- `frame_count` out 16: completed frames; wraps from 0xFFFF to 0.

## Operation
State machine: IDLE → FV_LEAD → LINE → LINE_GAP → (LINE | FRAME_GAP) → (FV_LEAD | IDLE).

Transitions:
- **IDLE:** `en`=1 sampled → FV_LEAD. The same edge registers `img_fv`=1, latches `mode`/`const_val`, and clears the pixel counter, row and col.
- **FV_LEAD:** lasts `FvLeadCycles` cycles, then → LINE.
- **LINE:** `img_lv`=1 for exactly `ImgWidth` cycles, with one new pixel per cycle; col increments each cycle. Then → LINE_GAP.
- **LINE_GAP:** `img_lv`=0 and `img_d`=0 for `LineGapCycles` cycles. If row < `ImgHeight`-1, increment row and → LINE. Otherwise → FRAME_GAP, registering `img_fv`=0, `frame_done`=1 and `frame_count`+1.
- **FRAME_GAP:** `FrameGapCycles` cycles. On the last cycle, `en`=1 → FV_LEAD (new frame, re-latch settings); `en`=0 → IDLE.

Run control:
- `en` is examined only in IDLE and on the last FRAME_GAP cycle.
- Dropping `en` mid-frame never truncates the frame.

Patterns (selected by `mode` as latched at frame start; mid-frame changes are ignored):
- 0: `~px` (bitwise inverse of the pixel counter).
- 1: `px`.
- 2: all-ones when row[1:0]==0 and col[1:0]==0; 0 otherwise (histogram test).
- 3: `const_val` as latched.

Widths and counters:
- `px` is a PixelWidth-bit counter that increments once per LINE cycle, wraps mod 2^PixelWidth, and clears at each frame start.
- row and col counters are `$clog2` of their bound, with a minimum of 1 bit.
- `img_d` is 0 whenever `img_lv`=0.

Reset (any time, including mid-line): all outputs go to 0 immediately, `frame_count`=0, state=IDLE. After `rst_` rises, the first frame starts on the first edge with `en`=1.

## Timing
- Latency from `en` sampled in IDLE to `img_fv`=1: 1 cycle.
- The first `img_lv` rises `FvLeadCycles` edges after `img_fv` rises.
- `img_d` is valid in the same cycle as `img_lv`=1. Pixel n of a frame appears on the n-th LINE cycle of that frame.
- Cycles per frame with `img_fv` high: `FvLeadCycles` + `ImgHeight`·(`ImgWidth`+`LineGapCycles`).
- Continuous-run period: the value above + `FrameGapCycles`.
- `frame_done` and `frame_count` update on the same edge that drops `img_fv`.
- `busy` falls on the edge that enters IDLE.

## Structure
- Package `img_pkg` holds:
  - the state enum (`ImgGenState`: IDLE, FV_LEAD, LINE, LINE_GAP, FRAME_GAP);
  - mode constants `ImgModeInvCount`=0, `ImgModeCount`=1, `ImgModeChecker`=2, `ImgModeConst`=3.
- One sub-module, `img_px_pattern`: combinational mapping of (mode, px, row[1:0], col[1:0], const_val) to pixel value. The top module registers its output.
- A single shared down-counter is reused for the lead, line and gap phases.

## Test plan
Benches use `ImgWidth`=4, `ImgHeight`=2, `PixelWidth`=12 and all gaps = 6.
- **Mode 0 single frame:** pulse `en` for 1 cycle. Required response:
  - `img_fv` high 6+2·(4+6)=26 cycles;
  - `img_d` sequence FFF, FFE, FFD, FFC, FFB, FFA, FF9, FF8;
  - `frame_done` is a single pulse, `frame_count`=1, then IDLE.
- **Continuous mode 1 with `en` held:** rising edges of `img_fv` are 32 cycles apart; each frame's data is 0..7; `frame_count` reaches 3 after three frames.
- **Mode 2, `ImgWidth`=8, `ImgHeight`=5:** FFF only at (row,col) ∈ {0,4}×{0,4}; 0 everywhere else.
- **Mode 3, `const_val`=0x5A5, changed to 0x123 mid-frame:** that frame is all 0x5A5; the next frame is all 0x123.
- **Reset and stop behaviour:**
  - Assert `rst_` low during line 1, pixel 2: outputs are 0 asynchronously, `frame_count`=0, and a fresh frame restarts at px=0 after release.
  - Drop `en` mid-frame: the frame completes fully, then `busy`=0.
- **Wrap:** `PixelWidth`=2, `ImgWidth`=6, mode 1: data 0,1,2,3,0,1.
